// File: rtl/pc_sequencer.sv
// Program counter sequencer: increment, pc-relative branch, jump, call/return
// through a circular return-address stack, and trap redirection.
module pc_sequencer #(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  OFF_WIDTH    = 16,
  parameter int                  INC          = 4,
  parameter int                  RAS_DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = 'h100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       update,
  input  logic                       branch,
  input  logic [OFF_WIDTH-1:0]       branch_offset,
  input  logic                       jump,
  input  logic                       call,
  input  logic [PC_WIDTH-1:0]        target,
  input  logic                       ret,
  input  logic                       trap,
  output logic [PC_WIDTH-1:0]        pc,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ras_overflow,
  output logic                       ras_underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;   // slot the next push writes
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                push;

  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]       ptr_dec;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] offset_ext;

  assign ptr_dec    = ptr_q - 1'b1;
  assign seq_pc     = pc_q + PC_WIDTH'(INC);
  assign offset_ext = PC_WIDTH'($signed(branch_offset));

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (update) begin
      if (trap) begin
        pc_d = TRAP_VECTOR;
      end else if (ret) begin
        if (cnt_q == '0) begin
          pc_d  = TRAP_VECTOR;
          unf_d = 1'b1;
        end else begin
          pc_d  = ras_q[ptr_dec];
          ptr_d = ptr_dec;
          cnt_d = cnt_q - 1'b1;
        end
      end else if (call) begin
        // When full, ptr_q already points at the oldest entry, so the push
        // overwrites it and the count saturates.
        push  = 1'b1;
        pc_d  = target;
        ptr_d = ptr_q + 1'b1;
        if (cnt_q == DEPTH_C) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end else if (jump) begin
        pc_d = target;
      end else if (branch) begin
        pc_d = pc_q + offset_ext;
      end else begin
        pc_d = seq_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      ptr_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push && !rst) ras_q[ptr_q] <= seq_pc;
  end

  assign pc            = pc_q;
  assign ras_count     = cnt_q;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == DEPTH_C);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then randomized traffic, all
// checked against a queue-based reference model of the sequencing rules.
module tb_pc_sequencer;
  localparam int          DEPTH = 4;
  localparam logic [31:0] TRAPV = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        update = 1'b0, branch = 1'b0, jump = 1'b0, call = 1'b0;
  logic        ret = 1'b0, trap = 1'b0;
  logic [15:0] branch_offset = '0;
  logic [31:0] target = '0;
  logic [31:0] pc;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .update(update), .branch(branch),
    .branch_offset(branch_offset), .jump(jump), .call(call),
    .target(target), .ret(ret), .trap(trap), .pc(pc),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  logic        m_ovf, m_unf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"}, 64'(pc), 64'(m_pc));
    check({tag, ".cnt"}, 64'(ras_count), 64'(m_stk.size()));
    check({tag, ".empty"}, 64'(ras_empty), 64'(m_stk.size() == 0));
    check({tag, ".full"}, 64'(ras_full), 64'(m_stk.size() == DEPTH));
    check({tag, ".ovf"}, 64'(ras_overflow), 64'(m_ovf));
    check({tag, ".unf"}, 64'(ras_underflow), 64'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Reset pulse placed between clock edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    compare_all(tag);
    rst = 1'b0;
  endtask

  task automatic cycle(input string tag, input bit u, input bit t, input bit r,
                       input bit c, input bit j, input bit b,
                       input logic [15:0] off, input logic [31:0] tgt);
    update = u; trap = t; ret = r; call = c; jump = j; branch = b;
    branch_offset = off; target = tgt;
    if (u) begin
      if (t) m_pc = TRAPV;
      else if (r) begin
        if (m_stk.size() == 0) begin
          m_pc = TRAPV;
          m_unf = 1'b1;
        end else m_pc = m_stk.pop_back();
      end else if (c) begin
        if (m_stk.size() == DEPTH) begin
          void'(m_stk.pop_front());
          m_ovf = 1'b1;
        end
        m_stk.push_back(m_pc + 32'd4);
        m_pc = tgt;
      end else if (j) m_pc = tgt;
      else if (b) m_pc = m_pc + {{16{off[15]}}, off};
      else m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    $display("%s u=%0b t=%0b r=%0b c=%0b j=%0b b=%0b -> pc=%08h cnt=%0d", tag, u, t, r, c, j, b, pc, ras_count);
    compare_all(tag);
  endtask

  logic [31:0] ret_exp [4];

  initial begin
    ret_exp[0] = 32'h1304; ret_exp[1] = 32'h1204;
    ret_exp[2] = 32'h1104; ret_exp[3] = 32'h1004;
    @(posedge clk);
    #1;
    do_reset("reset");
    check("reset.pc0", 64'(pc), 64'h0);

    for (int i = 1; i <= 3; i++) begin
      cycle("inc", 1, 0, 0, 0, 0, 0, '0, '0);
      check("inc.val", 64'(pc), 64'(4 * i));
    end

    cycle("jmp40", 1, 0, 0, 0, 1, 0, '0, 32'h40);
    cycle("br_back", 1, 0, 0, 0, 0, 1, 16'hFFF0, '0);
    check("br_back.val", 64'(pc), 64'h30);
    cycle("br_fwd", 1, 0, 0, 0, 0, 1, 16'h0010, '0);
    check("br_fwd.val", 64'(pc), 64'h40);

    cycle("jmp10", 1, 0, 0, 0, 1, 0, '0, 32'h10);
    cycle("call200", 1, 0, 0, 1, 0, 0, '0, 32'h200);
    check("call200.pc", 64'(pc), 64'h200);
    check("call200.cnt", 64'(ras_count), 64'd1);
    cycle("ret14", 1, 0, 1, 0, 0, 0, '0, '0);
    check("ret14.pc", 64'(pc), 64'h14);
    check("ret14.empty", 64'(ras_empty), 64'd1);

    cycle("jmp500", 1, 0, 0, 0, 1, 0, '0, 32'h500);
    for (int k = 0; k < 5; k++)
      cycle("nest_call", 1, 0, 0, 1, 0, 0, '0, 32'h1000 + 32'(k) * 32'h100);
    check("nest.full", 64'(ras_full), 64'd1);
    check("nest.ovf", 64'(ras_overflow), 64'd1);
    for (int k = 0; k < 4; k++) begin
      cycle("nest_ret", 1, 0, 1, 0, 0, 0, '0, '0);
      check("nest_ret.lifo", 64'(pc), 64'(ret_exp[k]));
    end
    cycle("under_ret", 1, 0, 1, 0, 0, 0, '0, '0);
    check("under.pc", 64'(pc), 64'(TRAPV));
    check("under.unf", 64'(ras_underflow), 64'd1);
    check("under.cnt", 64'(ras_count), 64'd0);

    cycle("call_pre", 1, 0, 0, 1, 0, 0, '0, 32'h800);
    cycle("prio_all", 1, 1, 1, 1, 0, 1, 16'h0020, 32'h900);
    check("prio.pc", 64'(pc), 64'(TRAPV));
    check("prio.cnt", 64'(ras_count), 64'd1);
    cycle("hold_all", 0, 1, 1, 1, 0, 1, 16'h0020, 32'h900);
    check("hold.pc", 64'(pc), 64'(TRAPV));
    check("hold.cnt", 64'(ras_count), 64'd1);
    cycle("callret", 1, 0, 1, 1, 0, 0, '0, 32'hA00);
    check("callret.pc", 64'(pc), 64'h104);

    cycle("jmp_top", 1, 0, 0, 0, 1, 0, '0, 32'hFFFF_FFFC);
    cycle("wrap", 1, 0, 0, 0, 0, 0, '0, '0);
    check("wrap.pc", 64'(pc), 64'h0);
    do_reset("midreset");
    check("midreset.ovf", 64'(ras_overflow), 64'd0);
    check("midreset.unf", 64'(ras_underflow), 64'd0);

    // Call presented while reset is held must be discarded.
    cycle("pre", 1, 0, 0, 0, 1, 0, '0, 32'h60);
    rst = 1'b1;
    update = 1'b1; call = 1'b1; target = 32'h700;
    model_reset();
    @(posedge clk);
    #1;
    check("rstcall.pc", 64'(pc), 64'h0);
    check("rstcall.cnt", 64'(ras_count), 64'd0);
    rst = 1'b0;
    cycle("after_rst", 1, 0, 0, 0, 0, 0, '0, '0);
    check("after_rst.pc", 64'(pc), 64'h4);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) do_reset("rnd_rst");
      else cycle("rnd", $urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 25, 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL take parameter PC_WIDTH, default 32, meaning the program counter width in bits.
REQ-002 The block SHALL take parameter OFF_WIDTH, default 16, meaning the branch offset width in bits (two's complement).
REQ-003 The block SHALL take parameter INC, default 4, meaning the sequential increment amount.
REQ-004 The block SHALL take parameter RAS_DEPTH, default 4, meaning the number of return-address stack entries (power of 2, at least 2).
REQ-005 The block SHALL take parameter RESET_VECTOR, default 0, meaning the pc value after reset.
REQ-006 The block SHALL take parameter TRAP_VECTOR, default 32'h100, meaning the pc value on trap or return underflow.
REQ-007 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port update, input, 1 bit: advance enable; when low, all control inputs are ignored.
REQ-010 The block SHALL have port branch, input, 1 bit: take a pc-relative branch.
REQ-011 The block SHALL have port branch_offset, input, OFF_WIDTH bits: signed branch displacement.
REQ-012 The block SHALL have port jump, input, 1 bit: absolute jump.
REQ-013 The block SHALL have port call, input, 1 bit: absolute jump that pushes the return address.
REQ-014 The block SHALL have port target, input, PC_WIDTH bits: destination for jump and call.
REQ-015 The block SHALL have port ret, input, 1 bit: pop the return address into pc.
REQ-016 The block SHALL have port trap, input, 1 bit: redirect to TRAP_VECTOR.
REQ-017 The block SHALL have port pc, output, PC_WIDTH bits: current program counter (registered).
REQ-018 The block SHALL have port ras_count, output, clog2(RAS_DEPTH)+1 bits: number of valid stack entries.
REQ-019 The block SHALL have ports ras_empty and ras_full, output, 1 bit each: ras_count==0 and ras_count==RAS_DEPTH respectively.
REQ-020 The block SHALL have ports ras_overflow and ras_underflow, output, 1 bit each: sticky error flags.

Function
REQ-021 When update=0, pc, stack contents, ras_count and the flags SHALL hold their values.
REQ-022 When update=1, exactly one action SHALL be applied per cycle, chosen by fixed priority: trap > ret > call > jump > branch > increment.
REQ-023 Trap SHALL set pc to TRAP_VECTOR and leave the stack unchanged.
REQ-024 Ret with ras_count>0 SHALL set pc to the top entry and decrement ras_count.
REQ-025 Ret with ras_count==0 SHALL set pc to TRAP_VECTOR and set ras_underflow; ras_count SHALL stay 0.
REQ-026 Call SHALL push pc+INC (mod 2^PC_WIDTH), set pc to target, and increment ras_count.
REQ-027 Call with ras_count==RAS_DEPTH SHALL overwrite the oldest entry (circular buffer) and set ras_overflow; ras_count SHALL stay RAS_DEPTH, and the new entry SHALL become the top.
REQ-028 Jump SHALL set pc to target with no stack effect.
REQ-029 Branch SHALL set pc to pc plus branch_offset sign-extended to PC_WIDTH, modulo 2^PC_WIDTH.
REQ-030 Increment SHALL set pc to pc+INC, modulo 2^PC_WIDTH; wrap-around from all-ones is legal and unflagged.
REQ-031 Lower-priority requests asserted in the same cycle SHALL be discarded, not queued; for example, call+ret together performs ret only.
REQ-032 ras_empty, ras_full and ras_count SHALL reflect registered state with no combinational path from inputs.
REQ-033 ras_overflow and ras_underflow, once set, SHALL remain set until reset.

Reset
REQ-034 Assertion of rst SHALL immediately, without a clock, set pc=RESET_VECTOR, ras_count=0, ras_overflow=0 and ras_underflow=0; stack entry contents need not be cleared.
REQ-035 Reset asserted mid-operation, including during a call or ret cycle, SHALL discard that action; the first action after rst deasserts is taken on the next rising clk edge with update=1.

Verification
REQ-036 Reset, then 3 cycles with update=1 and no requests -> pc = 0, 4, 8, 12.
REQ-037 At pc=0x40, branch with offset 16'hFFF0 -> pc=0x30; at pc=0x30, offset 16'h0010 -> pc=0x40.
REQ-038 At pc=0x10, call target=0x200 -> pc=0x200 and ras_count=1; then ret -> pc=0x14 and ras_empty=1.
REQ-039 Five nested calls with RAS_DEPTH=4 -> ras_full=1 and ras_overflow=1; four rets return in LIFO order (most recent first); a fifth ret -> pc=TRAP_VECTOR and ras_underflow=1.
REQ-040 trap+ret+call+branch in one cycle -> pc=TRAP_VECTOR with ras_count unchanged; the same inputs with update=0 -> no change.
REQ-041 At pc=32'hFFFFFFFC, increment -> pc=0; rst pulsed between clock edges -> pc returns to RESET_VECTOR immediately and both flags clear.
